// File: rtl/frame_scan_ctrl_if.sv
// Loader-port and pixel-stream bundle between frame_scan_ctrl (master) and the loader/filter side (slave).
// rd_data is combinational from rd_row/rd_col; the stream uses a valid/ready handshake with frame/line markers.
interface frame_scan_ctrl_if #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 512,
  parameter int BPP    = 8
);
  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic             rd_req;
  logic [ROW_W-1:0] rd_row;
  logic [COL_W-1:0] rd_col;
  logic [BPP-1:0]   rd_data;

  logic             m_valid;
  logic             m_ready;
  logic [BPP-1:0]   m_data;
  logic             m_sof;
  logic             m_eol;
  logic             m_eof;

  modport master (
    output rd_req, rd_row, rd_col,
    input  rd_data,
    output m_valid, m_data, m_sof, m_eol, m_eof,
    input  m_ready
  );

  modport slave (
    input  rd_req, rd_row, rd_col,
    output rd_data,
    input  m_valid, m_data, m_sof, m_eol, m_eof,
    output m_ready
  );
endinterface

// File: rtl/frame_scan_ctrl.sv
// Frame loader sequencer: rd_req, LOAD_CYCLES settle, then zero-latency raster stream held under m_ready stalls.
// Define FRAME_SCAN_HBLANK_EN to insert H_BLANK idle cycles after every non-final line.
module frame_scan_ctrl #(
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 512,
  parameter int BPP         = 8,
  parameter int LOAD_CYCLES = 6,
  parameter int H_BLANK     = 4
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                start,
  input  logic                abort,
  input  logic [15:0]         num_frames,
  output logic                busy,
  output logic                done,
  output logic [15:0]         frame_idx,
  frame_scan_ctrl_if.master   bus
);

  localparam int ROW_W  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int COL_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int WAIT_W = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(HEIGHT - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(WIDTH - 1);
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(LOAD_CYCLES - 1);
`ifdef FRAME_SCAN_HBLANK_EN
  localparam int BLK_W = (H_BLANK > 1) ? $clog2(H_BLANK) : 1;
  localparam logic [BLK_W-1:0] BLK_INIT = BLK_W'((H_BLANK > 0) ? H_BLANK - 1 : 0);
`endif

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    LOAD_WAIT,
    STREAM,
`ifdef FRAME_SCAN_HBLANK_EN
    BLANK,
`endif
    FRAME_END,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [15:0]       left_q, left_d;
  logic [15:0]       fidx_q, fidx_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
`ifdef FRAME_SCAN_HBLANK_EN
  logic [BLK_W-1:0]  blank_q, blank_d;
`endif

  logic hs;
  logic last_col;
  logic last_row;

  assign hs       = (state_q == STREAM) && bus.m_ready;
  assign last_col = (col_q == LAST_COL);
  assign last_row = (row_q == LAST_ROW);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    left_d  = left_q;
    fidx_d  = fidx_q;
    row_d   = row_q;
    col_d   = col_q;
`ifdef FRAME_SCAN_HBLANK_EN
    blank_d = blank_q;
`endif

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          fidx_d = '0;
          row_d  = '0;
          col_d  = '0;
          if (num_frames == 16'd0) begin
            left_d  = '0;
            state_d = DONE;
          end else begin
            left_d  = num_frames - 16'd1;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        wait_d  = WAIT_INIT;
        state_d = LOAD_WAIT;
      end
      LOAD_WAIT: begin
        if (wait_q == '0) begin
          row_d   = '0;
          col_d   = '0;
          state_d = STREAM;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      STREAM: begin
        if (hs) begin
          if (last_col) begin
            col_d = '0;
            if (last_row) begin
              row_d   = '0;
              state_d = FRAME_END;
            end else begin
              row_d = row_q + 1'b1;
`ifdef FRAME_SCAN_HBLANK_EN
              if (H_BLANK > 0) begin
                blank_d = BLK_INIT;
                state_d = BLANK;
              end
`endif
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
`ifdef FRAME_SCAN_HBLANK_EN
      BLANK: begin
        if (blank_q == '0) begin
          state_d = STREAM;
        end else begin
          blank_d = blank_q - 1'b1;
        end
      end
`endif
      FRAME_END: begin
        row_d = '0;
        col_d = '0;
        if (left_q != 16'd0) begin
          left_d  = left_q - 16'd1;
          fidx_d  = fidx_q + 16'd1;
          state_d = REQ;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // abort overrides everything, including a handshake in the same cycle
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      wait_d  = '0;
      left_d  = '0;
      fidx_d  = '0;
      row_d   = '0;
      col_d   = '0;
`ifdef FRAME_SCAN_HBLANK_EN
      blank_d = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wait_q  <= '0;
      left_q  <= '0;
      fidx_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
`ifdef FRAME_SCAN_HBLANK_EN
      blank_q <= '0;
`endif
    end else begin
      wait_q  <= wait_d;
      left_q  <= left_d;
      fidx_q  <= fidx_d;
      row_q   <= row_d;
      col_q   <= col_d;
`ifdef FRAME_SCAN_HBLANK_EN
      blank_q <= blank_d;
`endif
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign frame_idx = fidx_q;

  assign bus.rd_req  = (state_q == REQ);
  assign bus.rd_row  = row_q;
  assign bus.rd_col  = col_q;
  assign bus.m_valid = (state_q == STREAM);
  assign bus.m_data  = bus.m_valid ? bus.rd_data : '0;
  assign bus.m_sof   = bus.m_valid && (row_q == '0) && (col_q == '0);
  assign bus.m_eol   = bus.m_valid && last_col;
  assign bus.m_eof   = bus.m_valid && last_col && last_row;

endmodule

// File: tb/tb_frame_scan_ctrl.sv
// Directed-plus-random bench for frame_scan_ctrl on a 4x3 frame; beats are scored against an expected raster list.
module tb_frame_scan_ctrl;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int LC = 2;
  localparam int HB = 2;
`ifdef FRAME_SCAN_HBLANK_EN
  localparam int GAP = HB;
`else
  localparam int GAP = 0;
`endif

  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] num_frames = 16'd0;
  logic        busy;
  logic        done;
  logic [15:0] frame_idx;
  logic [7:0]  salt = 8'd0;

  always #5 clk = ~clk;

  frame_scan_ctrl_if #(.WIDTH(W), .HEIGHT(H), .BPP(8)) bus ();

  frame_scan_ctrl #(
    .WIDTH(W), .HEIGHT(H), .BPP(8), .LOAD_CYCLES(LC), .H_BLANK(HB)
  ) dut (
    .clk(clk),
    .rstb(rstb),
    .start(start),
    .abort(abort),
    .num_frames(num_frames),
    .busy(busy),
    .done(done),
    .frame_idx(frame_idx),
    .bus(bus.master)
  );

  // loader image: pixel value is its raster index, optionally scrambled per run
  assign bus.rd_data = 8'(int'(bus.rd_row) * W + int'(bus.rd_col)) ^ salt;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- monitor ----------------
  int          cyc = 0;
  logic [26:0] got_q[$];
  int          beat_cyc_q[$];
  int          req_cyc_q[$];
  int          done_cyc_q[$];
  int          sof_rise_q[$];
  int          valid_cnt = 0;
  int          stall_err = 0;
  logic        pv = 1'b0, pstall = 1'b0, pabort = 1'b0;
  logic [26:0] pheld = '0;
  logic [26:0] cur;

  assign cur = {frame_idx, bus.m_data, bus.m_sof, bus.m_eol, bus.m_eof};

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.m_valid && bus.m_ready) begin
      got_q.push_back(cur);
      beat_cyc_q.push_back(cyc);
    end
    if (bus.rd_req) req_cyc_q.push_back(cyc);
    if (done) done_cyc_q.push_back(cyc);
    if (bus.m_valid) valid_cnt <= valid_cnt + 1;
    if (bus.m_valid && bus.m_sof && !pv) sof_rise_q.push_back(cyc);
    if (pstall && !pabort && rstb && (!bus.m_valid || cur != pheld)) stall_err <= stall_err + 1;
    pstall <= bus.m_valid && !bus.m_ready;
    pheld  <= cur;
    pv     <= bus.m_valid;
    pabort <= abort;
  end

  // ---------------- driver helpers ----------------
  int rmode = 0;
  int rphase = 0;
  logic [26:0] exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
    rphase++;
    case (rmode)
      0:       bus.m_ready = 1'b1;
      1:       bus.m_ready = (rphase % 3 == 0);
      default: bus.m_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic clear_logs();
    got_q.delete();
    beat_cyc_q.delete();
    req_cyc_q.delete();
    done_cyc_q.delete();
    sof_rise_q.delete();
    valid_cnt = 0;
    stall_err = 0;
  endtask

  task automatic build_exp(input int n);
    exp_q.delete();
    for (int f = 0; f < n; f++)
      for (int p = 0; p < W * H; p++)
        exp_q.push_back({16'(f), 8'(p) ^ salt, (p == 0), (p % W == W - 1), (p == W * H - 1)});
  endtask

  task automatic start_run(input logic [15:0] n);
    num_frames = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin
      tick();
      k++;
    end
    chk({tag, "_idle_in_time"}, 32'(k < budget), 32'd1);
    tick();
  endtask

  task automatic check_run(input string tag, input int n, input bit timing);
    int nb;
    chk({tag, "_beats"}, got_q.size(), n * W * H);
    nb = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < nb; i++)
      chk($sformatf("%s_beat%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    chk({tag, "_rd_req"}, req_cyc_q.size(), n);
    chk({tag, "_done"}, done_cyc_q.size(), 1);
    chk({tag, "_stall_stable"}, stall_err, 0);
    for (int f = 0; f < n && f < sof_rise_q.size() && f < req_cyc_q.size(); f++)
      chk($sformatf("%s_latency%0d", tag, f), sof_rise_q[f] - req_cyc_q[f], LC + 1);
    if (done_cyc_q.size() > 0 && beat_cyc_q.size() > 0)
      chk({tag, "_done_delay"}, done_cyc_q[0] - beat_cyc_q[beat_cyc_q.size() - 1], 2);
    if (timing)
      for (int i = 1; i < beat_cyc_q.size(); i++)
        chk($sformatf("%s_gap%0d", tag, i), beat_cyc_q[i] - beat_cyc_q[i - 1],
            (i % (W * H) == 0) ? LC + 3 : ((i % W == 0) ? GAP + 1 : 1));
  endtask

  // ---------------- sequence ----------------
  initial begin
    int n;
    int k;
    bus.m_ready = 1'b1;

    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_req", bus.rd_req, 0);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_rd_row", bus.rd_row, 0);
    chk("rst_rd_col", bus.rd_col, 0);
    chk("rst_frame_idx", frame_idx, 0);
    tick();
    rstb = 1'b1;
    tick();

    // basic frame with the plain row*4+col image
    rmode = 0; salt = 8'd0;
    clear_logs(); build_exp(1);
    start_run(1);
    wait_idle("basic", 200);
    chk("basic_busy_after", busy, 0);
    check_run("basic", 1, 1'b1);

    // backpressure 1,0,0 pattern
    rmode = 1; salt = 8'($urandom);
    clear_logs(); build_exp(1);
    start_run(1);
    wait_idle("bp", 400);
    check_run("bp", 1, 1'b0);

    // three back-to-back frames
    rmode = 0; salt = 8'($urandom);
    clear_logs(); build_exp(3);
    start_run(3);
    wait_idle("multi", 400);
    check_run("multi", 3, 1'b1);

    // random ready, random frame count
    for (int r = 0; r < 2; r++) begin
      rmode = 2; salt = 8'($urandom);
      n = $urandom_range(1, 3);
      clear_logs(); build_exp(n);
      start_run(16'(n));
      wait_idle("rand", 800);
      check_run("rand", n, 1'b0);
    end

    // zero frames
    rmode = 0;
    clear_logs();
    start_run(0);
    wait_idle("zero", 20);
    chk("zero_done", done_cyc_q.size(), 1);
    chk("zero_rd_req", req_cyc_q.size(), 0);
    chk("zero_valid", valid_cnt, 0);

    // second start while busy is ignored
    salt = 8'($urandom);
    clear_logs(); build_exp(2);
    start_run(2);
    repeat (6) tick();
    num_frames = 16'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle("restart", 400);
    check_run("restart", 2, 1'b1);

    // start and abort together in IDLE
    clear_logs();
    num_frames = 16'd1;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("startabort_busy", busy, 0);
    repeat (3) tick();
    chk("startabort_rd_req", req_cyc_q.size(), 0);

    // abort on beat 5 with ready high
    salt = 8'($urandom);
    clear_logs(); build_exp(1);
    start_run(1);
    k = 0;
    while (!(bus.m_valid && int'(bus.rd_row) * W + int'(bus.rd_col) == 5) && k < 50) begin
      tick();
      k++;
    end
    chk("abort_reach_beat5", 32'(k < 50), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid_drop", bus.m_valid, 0);
    chk("abort_busy", busy, 0);
    repeat (4) tick();
    chk("abort_beats", got_q.size(), 6);
    chk("abort_no_done", done_cyc_q.size(), 0);
    for (int i = 0; i < 6 && i < got_q.size(); i++)
      chk($sformatf("abort_beat%0d", i), 32'(got_q[i]), 32'(exp_q[i]));

    // asynchronous reset while the second frame is in LOAD_WAIT
    clear_logs();
    start_run(2);
    k = 0;
    while (req_cyc_q.size() < 2 && k < 200) begin
      tick();
      k++;
    end
    chk("rstmid_reach", 32'(k < 200), 32'd1);
    chk("rstmid_pre_idx", frame_idx, 1);
    chk("rstmid_pre_busy", busy, 1);
    #1;
    rstb = 1'b0;
    #1;
    chk("rstmid_busy", busy, 0);
    chk("rstmid_frame_idx", frame_idx, 0);
    chk("rstmid_rd_req", bus.rd_req, 0);
    chk("rstmid_valid", bus.m_valid, 0);
    chk("rstmid_eof", bus.m_eof, 0);
    tick();
    rstb = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
